climate_zone_ctrl: RTL and testbench

//  Multi-zone thermostat for the elevator cab/machine-room climate subsystem; parametrised successor of the single-zone controller.
//  Per zone: hysteresis band around a shared programmable setpoint, minimum on-time and minimum off-time (compressor/element protection).

---
 rtl/climate_pkg.sv | 30 +++
 rtl/climate_zone_fsm.sv | 134 +++++++++++++
 rtl/climate_zone_ctrl.sv | 50 +++++
 tb/tb_climate_zone_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/climate_pkg.sv
// Shared types and default sizing for the multi-zone climate controller.
package climate_pkg;

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        IDLE  = 3'd1,
        HEAT  = 3'd2,
        COOL  = 3'd3,
        DWELL = 3'd4,
        FAULT = 3'd5
    } zone_state_t;

    localparam int NUM_ZONES_DEF   = 4;
    localparam int TEMP_W_DEF      = 8;
    localparam int HYST_W_DEF      = 4;
    localparam int T_MIN_DEF       = -40;
    localparam int T_MAX_DEF       = 100;
    localparam int MIN_ON_CYC_DEF  = 4;
    localparam int MIN_OFF_CYC_DEF = 3;

    // One timer serves both hold and dwell, so it must count to the larger of the two.
    function automatic int tmr_width(input int on_cyc, input int off_cyc);
        int m;
        m = (on_cyc > off_cyc) ? on_cyc : off_cyc;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    localparam int TMR_W = tmr_width(MIN_ON_CYC_DEF, MIN_OFF_CYC_DEF);

endpackage

// File: rtl/climate_zone_fsm.sv
// One climate zone: hysteresis thermostat with minimum on-time, dwell and sticky range fault.
module climate_zone_fsm
    import climate_pkg::*;
#(
    parameter int TEMP_W      = TEMP_W_DEF,
    parameter int HYST_W      = HYST_W_DEF,
    parameter int T_MIN       = T_MIN_DEF,
    parameter int T_MAX       = T_MAX_DEF,
    parameter int MIN_ON_CYC  = MIN_ON_CYC_DEF,
    parameter int MIN_OFF_CYC = MIN_OFF_CYC_DEF,
    parameter int TW          = TMR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              off_btn,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0] setpoint,
    input  logic [HYST_W-1:0] hyst,
    output logic              heater,
    output logic              cooler,
    output logic              fault
);

    localparam int W2           = TEMP_W + 2;
    localparam int ON_START_I   = (MIN_ON_CYC > 0) ? 1 : 0;
    localparam int OFF_START_I  = (MIN_OFF_CYC > 0) ? 1 : 0;

    localparam logic [TW-1:0] ON_MAX    = MIN_ON_CYC[TW-1:0];
    localparam logic [TW-1:0] OFF_MAX   = MIN_OFF_CYC[TW-1:0];
    localparam logic [TW-1:0] ON_START  = ON_START_I[TW-1:0];
    localparam logic [TW-1:0] OFF_START = OFF_START_I[TW-1:0];

    localparam logic signed [W2-1:0] T_MIN_X = T_MIN[W2-1:0];
    localparam logic signed [W2-1:0] T_MAX_X = T_MAX[W2-1:0];

    zone_state_t   state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;

    logic signed [W2-1:0] t_x, sp_x, hy_x, lo, hi;
    logic                 out_of_range;

    // Two extra bits keep setpoint +/- hyst exact at the extremes of the temperature range.
    assign t_x  = {{2{temp[TEMP_W-1]}}, temp};
    assign sp_x = {{2{setpoint[TEMP_W-1]}}, setpoint};
    assign hy_x = {{(W2-HYST_W){1'b0}}, hyst};
    assign lo   = sp_x - hy_x;
    assign hi   = sp_x + hy_x;

    assign out_of_range = sample_valid && ((t_x < T_MIN_X) || (t_x > T_MAX_X));

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        if (state != OFF && out_of_range) begin
            state_nxt = FAULT;
            timer_nxt = '0;
        end else begin
            case (state)
                OFF: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
                IDLE: begin
                    timer_nxt = '0;
                    if (sample_valid && t_x < lo) begin
                        state_nxt = HEAT;
                        timer_nxt = ON_START;
                    end else if (sample_valid && t_x > hi) begin
                        state_nxt = COOL;
                        timer_nxt = ON_START;
                    end
                end
                HEAT: begin
                    if (timer == ON_MAX && sample_valid && t_x >= sp_x) begin
                        state_nxt = DWELL;
                        timer_nxt = OFF_START;
                    end else if (timer < ON_MAX) begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                COOL: begin
                    if (timer == ON_MAX && sample_valid && t_x <= sp_x) begin
                        state_nxt = DWELL;
                        timer_nxt = OFF_START;
                    end else if (timer < ON_MAX) begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                DWELL: begin
                    if (timer >= OFF_MAX) begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                FAULT: begin
                    state_nxt = FAULT;
                    timer_nxt = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // The off button outranks reset and deliberately leaves the fault flag untouched.
    always_ff @(posedge clock) begin
        if (off_btn) begin
            state  <= OFF;
            timer  <= '0;
            heater <= 1'b0;
            cooler <= 1'b0;
        end else if (reset) begin
            state  <= IDLE;
            timer  <= '0;
            heater <= 1'b0;
            cooler <= 1'b0;
            fault  <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            heater <= (state_nxt == HEAT);
            cooler <= (state_nxt == COOL);
            if (state_nxt == FAULT) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/climate_zone_ctrl.sv
// Multi-zone thermostat top: one independent zone controller per sensor slice.
module climate_zone_ctrl
    import climate_pkg::*;
#(
    parameter int NUM_ZONES   = NUM_ZONES_DEF,
    parameter int TEMP_W      = TEMP_W_DEF,
    parameter int HYST_W      = HYST_W_DEF,
    parameter int T_MIN       = T_MIN_DEF,
    parameter int T_MAX       = T_MAX_DEF,
    parameter int MIN_ON_CYC  = MIN_ON_CYC_DEF,
    parameter int MIN_OFF_CYC = MIN_OFF_CYC_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        off_btn,
    input  logic [NUM_ZONES-1:0]        sample_valid,
    input  logic [NUM_ZONES*TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0]           setpoint,
    input  logic [HYST_W-1:0]           hyst,
    output logic [NUM_ZONES-1:0]        heater,
    output logic [NUM_ZONES-1:0]        cooler,
    output logic [NUM_ZONES-1:0]        fault
);

    localparam int TW = tmr_width(MIN_ON_CYC, MIN_OFF_CYC);

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        climate_zone_fsm #(
            .TEMP_W      (TEMP_W),
            .HYST_W      (HYST_W),
            .T_MIN       (T_MIN),
            .T_MAX       (T_MAX),
            .MIN_ON_CYC  (MIN_ON_CYC),
            .MIN_OFF_CYC (MIN_OFF_CYC),
            .TW          (TW)
        ) u_zone (
            .clock        (clock),
            .reset        (reset),
            .off_btn      (off_btn),
            .sample_valid (sample_valid[z]),
            .temp         (temp[z*TEMP_W +: TEMP_W]),
            .setpoint     (setpoint),
            .hyst         (hyst),
            .heater       (heater[z]),
            .cooler       (cooler[z]),
            .fault        (fault[z])
        );
    end

endmodule

// File: tb/tb_climate_zone_ctrl.sv
// Bench for climate_zone_ctrl: directed scenarios plus random traffic against a behavioural zone model.
module tb_climate_zone_ctrl;

    localparam int NZ      = 4;
    localparam int TW      = 8;
    localparam int MIN_ON  = 4;
    localparam int MIN_OFF = 3;
    localparam int LO_LIM  = -40;
    localparam int HI_LIM  = 100;

    localparam int M_OFF   = 0;
    localparam int M_IDLE  = 1;
    localparam int M_HEAT  = 2;
    localparam int M_COOL  = 3;
    localparam int M_DWELL = 4;
    localparam int M_FAULT = 5;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               off_btn = 1'b0;
    logic [NZ-1:0]      sample_valid = '0;
    logic [NZ*TW-1:0]   temp = '0;
    logic [TW-1:0]      setpoint = 8'd25;
    logic [3:0]         hyst = 4'd1;
    logic [NZ-1:0]      heater, cooler, fault;

    int  total = 0;
    int  bad = 0;
    bit  check_en = 1'b0;

    int  m_mode [NZ];
    int  m_cnt  [NZ];
    bit  m_fault[NZ];

    climate_zone_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .off_btn      (off_btn),
        .sample_valid (sample_valid),
        .temp         (temp),
        .setpoint     (setpoint),
        .hyst         (hyst),
        .heater       (heater),
        .cooler       (cooler),
        .fault        (fault)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Drives one cycle of samples, lets one edge pass and returns on the following falling edge.
    task automatic applyStimulus(input logic [NZ-1:0] v, input int t0, input int t1, input int t2, input int t3);
        sample_valid = v;
        temp[0*TW +: TW] = TW'(t0);
        temp[1*TW +: TW] = TW'(t1);
        temp[2*TW +: TW] = TW'(t2);
        temp[3*TW +: TW] = TW'(t3);
        @(posedge clock);
        @(negedge clock);
    endtask

    // Reference zone behaviour in terms of elapsed on/dwell cycles and plain integer thresholds.
    always @(posedge clock) begin
        int t, sp, hy;
        bit v;
        sp = int'($signed(setpoint));
        hy = int'(hyst);
        for (int z = 0; z < NZ; z++) begin
            t = int'($signed(temp[z*TW +: TW]));
            v = sample_valid[z];
            if (off_btn) begin
                m_mode[z] = M_OFF;
                m_cnt[z]  = 0;
            end else if (reset) begin
                m_mode[z]  = M_IDLE;
                m_cnt[z]   = 0;
                m_fault[z] = 1'b0;
            end else if (m_mode[z] != M_OFF && v && (t < LO_LIM || t > HI_LIM)) begin
                m_mode[z]  = M_FAULT;
                m_fault[z] = 1'b1;
            end else begin
                case (m_mode[z])
                    M_OFF:  m_mode[z] = M_IDLE;
                    M_IDLE: begin
                        if (v && t < sp - hy) begin
                            m_mode[z] = M_HEAT;
                            m_cnt[z]  = 1;
                        end else if (v && t > sp + hy) begin
                            m_mode[z] = M_COOL;
                            m_cnt[z]  = 1;
                        end
                    end
                    M_HEAT, M_COOL: begin
                        if (m_cnt[z] >= MIN_ON && v &&
                            ((m_mode[z] == M_HEAT && t >= sp) || (m_mode[z] == M_COOL && t <= sp))) begin
                            m_mode[z] = M_DWELL;
                            m_cnt[z]  = 1;
                        end else begin
                            m_cnt[z]++;
                        end
                    end
                    M_DWELL: begin
                        if (m_cnt[z] >= MIN_OFF) m_mode[z] = M_IDLE;
                        else m_cnt[z]++;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            checkOutput("heater_and_cooler", heater & cooler, 32'd0);
            for (int z = 0; z < NZ; z++) begin
                checkOutput($sformatf("model_heater_z%0d", z), heater[z], (m_mode[z] == M_HEAT));
                checkOutput($sformatf("model_cooler_z%0d", z), cooler[z], (m_mode[z] == M_COOL));
                checkOutput($sformatf("model_fault_z%0d", z), fault[z], m_fault[z]);
            end
        end
    end

    initial begin
        for (int z = 0; z < NZ; z++) begin
            m_mode[z] = M_IDLE; m_cnt[z] = 0; m_fault[z] = 1'b0;
        end
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(4'b0000, 0, 0, 0, 0);
        check_en = 1'b1;
        checkOutput("reset_outputs", {heater, cooler, fault}, 32'd0);
        reset = 1'b0;

        $display("[TB] heating with hold and dwell");
        applyStimulus(4'b0001, 23, 0, 0, 0);
        checkOutput("heat_start", heater[0], 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 25, 0, 0, 0);
            checkOutput("heat_min_on_hold", heater[0], 1'b1);
        end
        applyStimulus(4'b0001, 25, 0, 0, 0);
        checkOutput("heat_exit", heater[0], 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 10, 0, 0, 0);
            checkOutput("dwell_ignores_sample", heater[0], 1'b0);
        end
        applyStimulus(4'b0001, 10, 0, 0, 0);
        checkOutput("heat_after_dwell", heater[0], 1'b1);

        $display("[TB] cooling and band");
        applyStimulus(4'b0010, 0, 27, 0, 0);
        checkOutput("cool_start", cooler[1], 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0010, 0, 26, 0, 0);
            checkOutput("cool_hold", cooler[1], 1'b1);
        end
        applyStimulus(4'b0010, 0, 25, 0, 0);
        checkOutput("cool_exit", cooler[1], 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 0, 0, 0, 0);
        applyStimulus(4'b0010, 0, 24, 0, 0);
        checkOutput("inside_band", {heater[1], cooler[1]}, 32'd0);

        $display("[TB] range fault");
        applyStimulus(4'b0100, 0, 0, 101, 0);
        checkOutput("fault_set", {fault[2], heater[2], cooler[2]}, 32'b100);
        applyStimulus(4'b0100, 0, 0, 25, 0);
        checkOutput("fault_sticky", fault[2], 1'b1);
        reset = 1'b1;
        applyStimulus(4'b0000, 0, 0, 0, 0);
        reset = 1'b0;
        checkOutput("fault_cleared", fault, 32'd0);

        $display("[TB] off button");
        applyStimulus(4'b1001, 10, 0, 0, 120);
        checkOutput("off_pre_heat", {heater[0], fault[3]}, 32'b11);
        applyStimulus(4'b0010, 0, 40, 0, 0);
        checkOutput("off_pre_cool", cooler[1], 1'b1);
        off_btn = 1'b1;
        applyStimulus(4'b0000, 0, 0, 0, 0);
        checkOutput("off_outputs", {heater, cooler, fault}, 32'b0000_0000_1000);
        reset = 1'b1;
        applyStimulus(4'b0001, 10, 0, 0, 0);
        checkOutput("off_beats_reset", {heater, cooler, fault}, 32'b0000_0000_1000);
        off_btn = 1'b0;
        reset = 1'b0;
        applyStimulus(4'b0001, 10, 0, 0, 0);
        checkOutput("off_release_idle", heater[0], 1'b0);
        applyStimulus(4'b0001, 10, 0, 0, 0);
        checkOutput("after_release_heat", {heater[0], fault[3]}, 32'b11);

        $display("[TB] extremes");
        reset = 1'b1;
        applyStimulus(4'b0000, 0, 0, 0, 0);
        reset = 1'b0;
        setpoint = 8'sd127;
        hyst = 4'd15;
        applyStimulus(4'b0001, 100, 0, 0, 0);
        checkOutput("extreme_high_sp", heater[0], 1'b1);
        setpoint = 8'h80;
        applyStimulus(4'b0010, 0, -40, 0, 0);
        checkOutput("extreme_low_sp", {cooler[1], fault[1]}, 32'b10);

        $display("[TB] random traffic");
        reset = 1'b1;
        applyStimulus(4'b0000, 0, 0, 0, 0);
        reset = 1'b0;
        setpoint = 8'd25;
        hyst = 4'd1;
        for (int c = 0; c < 10000; c++) begin
            int tv [NZ];
            if ($urandom_range(0, 49) == 0) setpoint = TW'($urandom_range(10, 40));
            if ($urandom_range(0, 49) == 0) hyst = 4'($urandom_range(0, 4));
            off_btn = ($urandom_range(0, 199) == 0);
            reset   = ($urandom_range(0, 299) == 0);
            for (int z = 0; z < NZ; z++) begin
                if ($urandom_range(0, 99) < 2) tv[z] = int'($urandom_range(0, 170)) - 60;
                else tv[z] = int'($urandom_range(10, 40));
            end
            applyStimulus(4'($urandom_range(0, 15)), tv[0], tv[1], tv[2], tv[3]);
        end
        off_btn = 1'b0;
        reset = 1'b0;

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
